// File: rtl/stap_visa_pkg.sv
// Shared types and sizing helpers for the VISA override JTAG shift stage.
package stap_visa_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CAPTURED = 2'd1,
    SHIFTING = 2'd2
  } visa_shift_state_t;

  // Counter holds 0..WIDTH+1, the extra value marks an over-length shift.
  function automatic int unsigned visa_cnt_w(input int unsigned width);
    return $clog2(width + 2);
  endfunction

  function automatic int unsigned visa_cnt_sat(input int unsigned width);
    return width + 1;
  endfunction

endpackage

// File: rtl/stap_visa_shift_reg.sv
// JTAG DR shift stage for the VISA override register: capture, LSB-first shift,
// length-qualified update strobe and sticky length error.
module stap_visa_shift_reg
  import stap_visa_pkg::*;
#(
  parameter int unsigned SHIFT_REG_STAP_WIDTH_OF_TAPC_VISAOVR_DATA = 8,
  parameter logic [SHIFT_REG_STAP_WIDTH_OF_TAPC_VISAOVR_DATA-1:0] SHIFT_REG_STAP_VISAOVR_RESET_VALUE = '0,
  parameter bit SHIFT_REG_STAP_STRICT_LENGTH = 1'b1
) (
  input  logic                                                ftap_tck,
  input  logic                                                powergoodrst,
  input  logic                                                ftap_tdi,
  input  logic                                                selected_visa_reg,
  input  logic                                                stap_fsm_tlrs,
  input  logic                                                stap_fsm_capture_dr,
  input  logic                                                stap_fsm_shift_dr,
  input  logic                                                stap_fsm_update_dr,
  input  logic [SHIFT_REG_STAP_WIDTH_OF_TAPC_VISAOVR_DATA-1:0] visa_reg_parallel_in,
  output logic [SHIFT_REG_STAP_WIDTH_OF_TAPC_VISAOVR_DATA-1:0] visa_shift_register,
  output logic                                                visa_update_qual,
  output logic                                                visa_tdo,
  output logic                                                visa_tdo_en,
  output logic                                                visa_len_err,
  output logic [visa_cnt_w(SHIFT_REG_STAP_WIDTH_OF_TAPC_VISAOVR_DATA)-1:0] visa_shift_count
);

  localparam int unsigned W     = SHIFT_REG_STAP_WIDTH_OF_TAPC_VISAOVR_DATA;
  localparam int unsigned CNT_W = visa_cnt_w(W);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(W);
  localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(visa_cnt_sat(W));

  visa_shift_state_t r_state, w_state_nxt;
  logic [W-1:0]      r_shift, w_shift_nxt;
  logic [CNT_W-1:0]  r_count, w_count_nxt;
  logic              r_len_err, w_len_err_nxt;
  logic              r_tdo, r_tdo_en;
  logic              w_len_ok;

  assign w_len_ok = SHIFT_REG_STAP_STRICT_LENGTH ? (r_count == CNT_FULL)
                                                 : (r_count != '0);

  // Rising-edge state register
  always_ff @(posedge ftap_tck or posedge powergoodrst) begin
    if (powergoodrst) begin
      r_state   <= IDLE;
      r_shift   <= SHIFT_REG_STAP_VISAOVR_RESET_VALUE;
      r_count   <= '0;
      r_len_err <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_count   <= w_count_nxt;
      r_len_err <= w_len_err_nxt;
    end
  end

  // Next state: tlrs acts regardless of select, then capture > shift > update
  always_comb begin
    w_state_nxt   = r_state;
    w_shift_nxt   = r_shift;
    w_count_nxt   = r_count;
    w_len_err_nxt = r_len_err;
    if (stap_fsm_tlrs) begin
      w_state_nxt   = IDLE;
      w_shift_nxt   = SHIFT_REG_STAP_VISAOVR_RESET_VALUE;
      w_count_nxt   = '0;
      w_len_err_nxt = 1'b0;
    end else if (selected_visa_reg) begin
      if (stap_fsm_capture_dr) begin
        w_state_nxt = CAPTURED;
        w_shift_nxt = visa_reg_parallel_in;
        w_count_nxt = '0;
      end else if (stap_fsm_shift_dr) begin
        w_state_nxt = SHIFTING;
        w_shift_nxt = W'({ftap_tdi, r_shift} >> 1);
        w_count_nxt = (r_count == CNT_SAT) ? r_count : r_count + CNT_W'(1);
      end else if (stap_fsm_update_dr) begin
        w_state_nxt = IDLE;
        if ((r_state == IDLE) || ((r_state == SHIFTING) && !w_len_ok)) begin
          w_len_err_nxt = 1'b1;
        end
      end
    end
  end

  // TDO retimed on the falling edge so it is stable across the capturing rising edge
  always_ff @(negedge ftap_tck or posedge powergoodrst) begin
    if (powergoodrst) begin
      r_tdo    <= 1'b0;
      r_tdo_en <= 1'b0;
    end else begin
      r_tdo    <= r_shift[0];
      r_tdo_en <= selected_visa_reg & stap_fsm_shift_dr;
    end
  end

  // Built from registered state so it holds through the downstream falling-edge sample
  assign visa_update_qual = selected_visa_reg & stap_fsm_update_dr &
                            (r_state == SHIFTING) & w_len_ok;

  assign visa_shift_register = r_shift;
  assign visa_shift_count    = r_count;
  assign visa_len_err        = r_len_err;
  assign visa_tdo            = r_tdo;
  assign visa_tdo_en         = r_tdo_en;

endmodule

// File: tb/tb_stap_visa_shift_reg.sv
// Bench for stap_visa_shift_reg: three instances (W8 strict, W8 lenient, W1 strict)
// driven in parallel and compared against a transaction-level reference model.
module tb_stap_visa_shift_reg;

  localparam int NI = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic tdi = 1'b0, sel = 1'b0, tlrs = 1'b0, cap = 1'b0, shf = 1'b0, upd = 1'b0;
  logic [7:0] pin = 8'h00;

  logic [7:0] sr0, sr1;
  logic [0:0] sr2;
  logic [3:0] c0, c1;
  logic [1:0] c2;
  logic [2:0] q, td, te, le;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  stap_visa_shift_reg #(
    .SHIFT_REG_STAP_WIDTH_OF_TAPC_VISAOVR_DATA(8),
    .SHIFT_REG_STAP_VISAOVR_RESET_VALUE(8'h00),
    .SHIFT_REG_STAP_STRICT_LENGTH(1'b1)
  ) dut0 (
    .ftap_tck(clk), .powergoodrst(rst), .ftap_tdi(tdi), .selected_visa_reg(sel),
    .stap_fsm_tlrs(tlrs), .stap_fsm_capture_dr(cap), .stap_fsm_shift_dr(shf),
    .stap_fsm_update_dr(upd), .visa_reg_parallel_in(pin), .visa_shift_register(sr0),
    .visa_update_qual(q[0]), .visa_tdo(td[0]), .visa_tdo_en(te[0]),
    .visa_len_err(le[0]), .visa_shift_count(c0)
  );

  stap_visa_shift_reg #(
    .SHIFT_REG_STAP_WIDTH_OF_TAPC_VISAOVR_DATA(8),
    .SHIFT_REG_STAP_VISAOVR_RESET_VALUE(8'hC3),
    .SHIFT_REG_STAP_STRICT_LENGTH(1'b0)
  ) dut1 (
    .ftap_tck(clk), .powergoodrst(rst), .ftap_tdi(tdi), .selected_visa_reg(sel),
    .stap_fsm_tlrs(tlrs), .stap_fsm_capture_dr(cap), .stap_fsm_shift_dr(shf),
    .stap_fsm_update_dr(upd), .visa_reg_parallel_in(pin), .visa_shift_register(sr1),
    .visa_update_qual(q[1]), .visa_tdo(td[1]), .visa_tdo_en(te[1]),
    .visa_len_err(le[1]), .visa_shift_count(c1)
  );

  stap_visa_shift_reg #(
    .SHIFT_REG_STAP_WIDTH_OF_TAPC_VISAOVR_DATA(1),
    .SHIFT_REG_STAP_VISAOVR_RESET_VALUE(1'b1),
    .SHIFT_REG_STAP_STRICT_LENGTH(1'b1)
  ) dut2 (
    .ftap_tck(clk), .powergoodrst(rst), .ftap_tdi(tdi), .selected_visa_reg(sel),
    .stap_fsm_tlrs(tlrs), .stap_fsm_capture_dr(cap), .stap_fsm_shift_dr(shf),
    .stap_fsm_update_dr(upd), .visa_reg_parallel_in(pin[0:0]), .visa_shift_register(sr2),
    .visa_update_qual(q[2]), .visa_tdo(td[2]), .visa_tdo_en(te[2]),
    .visa_len_err(le[2]), .visa_shift_count(c2)
  );

  // Per-instance configuration
  function automatic int mw(input int k);
    return (k == 2) ? 1 : 8;
  endfunction
  function automatic bit mstrict(input int k);
    return (k != 1);
  endfunction
  function automatic logic [7:0] mrv(input int k);
    return (k == 0) ? 8'h00 : (k == 1) ? 8'hC3 : 8'h01;
  endfunction
  function automatic logic [7:0] mmask(input int k);
    return (k == 2) ? 8'h01 : 8'hFF;
  endfunction

  function automatic logic [7:0] obs_sr(input int k);
    return (k == 0) ? sr0 : (k == 1) ? sr1 : {7'b0, sr2};
  endfunction
  function automatic int obs_cnt(input int k);
    return (k == 0) ? int'(c0) : (k == 1) ? int'(c1) : int'(c2);
  endfunction

  // Reference model: data word, unbounded shift tally, sequence phase, sticky error
  localparam int PH_IDLE = 0, PH_CAP = 1, PH_SHIFT = 2;
  logic [7:0] m_reg [NI];
  int         m_n   [NI];
  int         m_ph  [NI];
  bit         m_err [NI];
  logic [2:0] last_q, last_td;

  task automatic model_reset();
    for (int k = 0; k < NI; k++) begin
      m_reg[k] = mrv(k); m_n[k] = 0; m_ph[k] = PH_IDLE; m_err[k] = 1'b0;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int k = 0; k < NI; k++) begin
      if (tlrs) begin
        m_reg[k] = mrv(k); m_n[k] = 0; m_ph[k] = PH_IDLE; m_err[k] = 1'b0;
      end else if (sel) begin
        if (cap) begin
          m_reg[k] = pin & mmask(k); m_n[k] = 0; m_ph[k] = PH_CAP;
        end else if (shf) begin
          m_reg[k] = ((m_reg[k] >> 1) | (8'(tdi) << (mw(k) - 1))) & mmask(k);
          m_n[k]++; m_ph[k] = PH_SHIFT;
        end else if (upd) begin
          if (m_ph[k] == PH_IDLE) m_err[k] = 1'b1;
          if (m_ph[k] == PH_SHIFT && mstrict(k) && m_n[k] != mw(k)) m_err[k] = 1'b1;
          m_ph[k] = PH_IDLE;
        end
      end
    end
  endtask

  function automatic logic qual_exp(input int k);
    bit len_ok;
    len_ok = mstrict(k) ? (m_n[k] == mw(k)) : (m_n[k] != 0);
    return sel & upd & (m_ph[k] == PH_SHIFT) & len_ok;
  endfunction

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] observed=%0h expected=%0h", tag, k, obs, exp);
    end
  endtask

  // One TCK cycle from posedge+1: check qual, then TDO after negedge, then registers after posedge
  task automatic cycle();
    #1;
    for (int k = 0; k < NI; k++) chk("qual", k, 32'(q[k]), 32'(qual_exp(k)));
    last_q = q;
    @(negedge clk); #1;
    for (int k = 0; k < NI; k++) begin
      chk("tdo", k, 32'(td[k]), rst ? 32'd0 : 32'(m_reg[k][0]));
      chk("tdo_en", k, 32'(te[k]), rst ? 32'd0 : 32'(sel & shf));
    end
    last_td = td;
    @(posedge clk);
    model_step();
    #1;
    for (int k = 0; k < NI; k++) begin
      chk("shift_reg", k, 32'(obs_sr(k)), 32'(m_reg[k]));
      chk("count", k, 32'(obs_cnt(k)), 32'((m_n[k] > mw(k) + 1) ? mw(k) + 1 : m_n[k]));
      chk("len_err", k, 32'(le[k]), 32'(m_err[k]));
    end
  endtask

  task automatic drive(input bit t, input bit s, input bit c, input bit sh, input bit u, input bit d);
    tlrs = t; sel = s; cap = c; shf = sh; upd = u; tdi = d;
    cycle();
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] stream;
    logic [9:0] word;
    int len;

    #2 rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < NI; k++) begin
      chk("rst_sr", k, 32'(obs_sr(k)), 32'(mrv(k)));
      chk("rst_cnt", k, 32'(obs_cnt(k)), 32'd0);
      chk("rst_err", k, 32'(le[k]), 32'd0);
      chk("rst_tdo", k, 32'(td[k]), 32'd0);
      chk("rst_tdo_en", k, 32'(te[k]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;

    // Nominal capture / 8 shifts / update
    pin = 8'hA5; pat = 8'h3C; stream = '0;
    drive(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      drive(0, 1, 0, 1, 0, pat[i]);
      stream[i] = last_td[0];
    end
    chk("tdo_stream", 0, 32'(stream), 32'h0A5);
    drive(0, 1, 0, 0, 1, 0);
    chk("qual_good", 0, 32'(last_q[0]), 32'd1);
    chk("qual_good_lenient", 1, 32'(last_q[1]), 32'd1);
    chk("sr_good", 0, 32'(sr0), 32'h3C);
    chk("err_good", 0, 32'(le[0]), 32'd0);
    drive(0, 1, 0, 0, 0, 0);
    chk("qual_after_upd", 0, 32'(last_q[0]), 32'd0);

    // Short shift sets sticky error that survives a good sequence
    drive(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) drive(0, 1, 0, 1, 0, 1'($urandom));
    drive(0, 1, 0, 0, 1, 0);
    chk("qual_short", 0, 32'(last_q[0]), 32'd0);
    chk("err_short", 0, 32'(le[0]), 32'd1);
    drive(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 1, 0, 1, 0, 1'($urandom));
    drive(0, 1, 0, 0, 1, 0);
    chk("qual_good2", 0, 32'(last_q[0]), 32'd1);
    chk("err_sticky", 0, 32'(le[0]), 32'd1);
    drive(1, 0, 0, 0, 0, 0);
    chk("err_tlrs_clr", 0, 32'(le[0]), 32'd0);

    // Over-length shift: strict blocks, lenient keeps last 8 bits
    pin = 8'($urandom);
    drive(0, 1, 1, 0, 0, 0);
    word = 10'($urandom);
    for (int i = 0; i < 10; i++) drive(0, 1, 0, 1, 0, word[i]);
    chk("cnt_sat", 0, 32'(c0), 32'd9);
    drive(0, 1, 0, 0, 1, 0);
    chk("qual_long", 0, 32'(last_q[0]), 32'd0);
    chk("qual_long_lenient", 1, 32'(last_q[1]), 32'd1);
    chk("err_long", 0, 32'(le[0]), 32'd1);
    chk("sr_long_lenient", 1, 32'(sr1), 32'(word[9:2]));

    // Capture then update, then update without capture
    drive(1, 1, 0, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 1, 0);
    chk("qual_noshift", 0, 32'(last_q[0]), 32'd0);
    chk("err_noshift", 0, 32'(le[0]), 32'd0);
    drive(0, 1, 0, 0, 1, 0);
    chk("err_nocapture", 0, 32'(le[0]), 32'd1);

    // Deselect mid-shift; count resumes on reselect
    drive(1, 1, 0, 0, 0, 0);
    pin = 8'($urandom);
    drive(0, 1, 1, 0, 0, 0);
    pat = 8'($urandom);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 1, 0, pat[i]);
    for (int i = 0; i < 3; i++) drive(0, 0, 0, 1, 0, 1'($urandom));
    for (int i = 4; i < 8; i++) drive(0, 1, 0, 1, 0, pat[i]);
    chk("cnt_resume", 0, 32'(c0), 32'd8);
    drive(0, 1, 0, 0, 1, 0);
    chk("qual_resume", 0, 32'(last_q[0]), 32'd1);
    chk("sr_resume", 0, 32'(sr0), 32'(pat));

    // Asynchronous reset during the fifth shift
    drive(1, 1, 0, 0, 0, 0);
    pin = 8'h5A;
    drive(0, 1, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, 1, 0, 1'b1);
    tlrs = 0; sel = 1; cap = 0; shf = 1; upd = 0; tdi = 1;
    #6 rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < NI; k++) begin
      chk("midrst_sr", k, 32'(obs_sr(k)), 32'(mrv(k)));
      chk("midrst_cnt", k, 32'(obs_cnt(k)), 32'd0);
      chk("midrst_tdo", k, 32'(td[k]), 32'd0);
      chk("midrst_tdo_en", k, 32'(te[k]), 32'd0);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive(0, 1, 0, 0, 1, 0);
    chk("qual_after_rst", 0, 32'(last_q[0]), 32'd0);

    // Capture and shift together: capture wins
    drive(1, 1, 0, 0, 0, 0);
    pin = 8'($urandom);
    drive(0, 1, 1, 1, 0, 1);
    chk("cap_wins_sr", 0, 32'(sr0), 32'(pin));
    chk("cap_wins_cnt", 0, 32'(c0), 32'd0);

    // Randomized transactions with deselect noise and stray updates
    repeat (60) begin
      if ($urandom_range(0, 5) == 0) drive(1, 1'($urandom), 0, 0, 0, 0);
      pin = 8'($urandom);
      drive(0, 1, 1, 0, 0, 0);
      len = $urandom_range(0, 10);
      if ($urandom_range(0, 2) == 0) len = 8;
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 4) == 0)
          drive(0, 0, 1'($urandom), 1, 1'($urandom), 1'($urandom));
        drive(0, 1, 0, 1, 0, 1'($urandom));
      end
      drive(0, 1, 0, 0, 1, 0);
      if ($urandom_range(0, 3) == 0)
        drive(1'($urandom_range(0, 7) == 0), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
